// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-3 sensor responder.
// Frame command byte layout is {rw, ms, addr[5:0]}, shifted MSB first.
package spi_pkg;

  localparam int REG_AW    = 6;
  localparam int REG_DEPTH = 1 << REG_AW;

  localparam int RW_BIT = 7;
  localparam int MS_BIT = 6;

  localparam logic [REG_AW-1:0] ID_ADDR_DEFAULT  = 6'h0F;
  localparam logic [7:0]        ID_VALUE_DEFAULT = 8'h33;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD,
    WR
  } state_e;

  // Address for the next byte of a multi-byte frame; 6-bit wrap is intended.
  function automatic logic [REG_AW-1:0] step_addr(input logic [REG_AW-1:0] addr,
                                                  input logic              inc);
    return inc ? addr + 1'b1 : addr;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with edge detection
// on the synchronized level. All flops preset to 1 (idle-high bus lines).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value, so the chain really is STAGES flops deep.
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-3 responder modelling a 64 x 8 accelerometer register file,
// with a host port for loading sample registers and observing SPI writes.
module spi_target
  import spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [REG_AW-1:0] ID_ADDR     = ID_ADDR_DEFAULT,
  parameter logic [7:0]        ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPC,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  logic w_spc_rise;
  logic w_spc_fall;
  logic w_spc_level;
  logic w_cs_level;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sdi;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_spc (
    .clk     (clk),
    .reset   (reset),
    .i_async (SPC),
    .o_level (w_spc_level),
    .o_rise  (w_spc_rise),
    .o_fall  (w_spc_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .reset   (reset),
    .i_async (CS),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk     (clk),
    .reset   (reset),
    .i_async (SDI),
    .o_level (w_sdi),
    .o_rise  (),
    .o_fall  ()
  );

  state_e            r_state;
  state_e            w_next_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_cmd_sr;
  logic [7:0]        r_rx_sr;
  logic [7:0]        r_tx_sr;
  logic [REG_AW-1:0] r_addr;
  logic              r_ms;
  logic              r_sdo;
  logic              r_wr_valid;
  logic [REG_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [3:0]        r_flush_cnt;
  logic              r_cs_armed;
  logic [7:0]        r_regs [REG_DEPTH];

  logic              w_byte_done;
  logic              w_commit;
  logic              w_flush_done;
  logic [7:0]        w_cmd_byte;
  logic [7:0]        w_rx_byte;
  logic [REG_AW-1:0] w_cmd_addr;
  logic [REG_AW-1:0] w_next_addr;

  assign w_byte_done  = w_spc_rise && (r_bit_cnt == 3'd7);
  assign w_cmd_byte   = {r_cmd_sr[6:0], w_sdi};
  assign w_rx_byte    = {r_rx_sr[6:0], w_sdi};
  assign w_cmd_addr   = w_cmd_byte[REG_AW-1:0];
  assign w_next_addr  = step_addr(r_addr, r_ms);
  assign w_flush_done = (r_flush_cnt == 4'(SYNC_STAGES));

  // After reset the CS chain still holds its preset for SYNC_STAGES clocks;
  // a frame is accepted only once real CS has been seen high after that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_cnt <= '0;
      r_cs_armed  <= 1'b0;
    end else begin
      if (!w_flush_done) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_flush_done && w_cs_level) begin
        r_cs_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_commit     = 1'b0;
    if (w_cs_level) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall && r_cs_armed) w_next_state = CMD;
        CMD:  if (w_byte_done) w_next_state = w_cmd_byte[RW_BIT] ? RD : WR;
        RD:   w_next_state = RD;
        WR:   w_commit = w_byte_done && (r_addr != ID_ADDR);
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_cmd_sr   <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_addr     <= '0;
      r_ms       <= 1'b0;
      r_sdo      <= 1'b1;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_next_state == IDLE) begin
        // Covers CS deassertion mid-byte: the partial byte is simply dropped.
        r_sdo     <= 1'b1;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          CMD: begin
            if (w_spc_rise) begin
              r_cmd_sr  <= w_cmd_byte;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_done) begin
                r_ms   <= w_cmd_byte[MS_BIT];
                r_addr <= w_cmd_addr;
                if (w_cmd_byte[RW_BIT]) r_tx_sr <= r_regs[w_cmd_addr];
              end
            end
          end
          RD: begin
            if (w_spc_fall) begin
              r_sdo   <= r_tx_sr[7];
              r_tx_sr <= r_tx_sr << 1;
            end
            if (w_spc_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_done) begin
                r_addr  <= w_next_addr;
                r_tx_sr <= r_regs[w_next_addr];
              end
            end
          end
          WR: begin
            if (w_spc_rise) begin
              r_rx_sr   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_done) begin
                r_addr <= w_next_addr;
                if (w_commit) begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_addr;
                  r_wr_data  <= w_rx_byte;
                end
              end
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  // Host write first, SPI commit last: on an address collision the SPI wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this array is reset on purpose (the model has defined power-up
      // contents), so it maps to flops rather than a RAM macro.
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_regs[i] <= (REG_AW'(i) == ID_ADDR) ? ID_VALUE : 8'h00;
      end
    end else begin
      if (host_we && (host_addr != ID_ADDR)) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_commit) begin
        r_regs[r_addr] <= w_rx_byte;
      end
    end
  end

  assign SDO        = r_sdo;
  assign host_rdata = r_regs[host_addr];
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = ~w_cs_level;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: host-port vector table, directed multi-cycle
// sequences, and random frames checked against an array-based register model.
module tb_spi_target;
  import spi_pkg::*;

  localparam int SS   = 2;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       SPC, CS, SDI;
  logic       SDO;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_valid;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  spi_target #(.SYNC_STAGES(SS), .ID_ADDR(6'h0F), .ID_VALUE(8'h33)) dut (
    .clk        (clk),
    .reset      (reset),
    .SPC        (SPC),
    .CS         (CS),
    .SDI        (SDI),
    .SDO        (SDO),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_ev_t;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    string      name;
  } host_vec_t;

  typedef logic [7:0] bytes_t [5];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [64];
  wr_ev_t     got_q [$];
  wr_ev_t     exp_q [$];
  bit         busy_ok;
  host_vec_t  hv [8];

  always @(negedge clk) begin
    if (!reset && wr_valid) got_q.push_back('{wr_addr, wr_data});
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = (i == 15) ? 8'h33 : 8'h00;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    if (a != 6'h0F) model[a] = d;
  endtask

  task automatic host_check(input logic [5:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    host_addr = a;
    #1;
    check(name, 32'(host_rdata), 32'(exp));
  endtask

  task automatic cs_start();
    @(posedge clk);
    #3;
    CS = 1'b0;
    busy_ok = 1'b1;
    #HALF;
  endtask

  task automatic cs_stop();
    CS = 1'b1;
    #200;
  endtask

  // One byte, MSB first; optionally fires a host write in the clk where
  // the DUT commits the last bit (SS+1 posedges after the SPC rise).
  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx,
                           input int nbits = 8, input bit collide = 1'b0,
                           input logic [5:0] ca = '0, input logic [7:0] cd = '0);
    rx = 8'hFF;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPC = 1'b0;
      SDI = tx[i];
      #HALF;
      SPC = 1'b1;
      rx[i] = SDO;
      busy_ok &= busy;
      if (collide && i == 0) begin
        repeat (SS) @(posedge clk);
        @(negedge clk);
        host_we = 1'b1; host_addr = ca; host_wdata = cd;
        @(negedge clk);
        host_we = 1'b0;
        #(HALF - 10 * SS - 12);
      end else begin
        #HALF;
      end
    end
  endtask

  task automatic frame(input bytes_t tx, input int n, output bytes_t rx);
    rx = '{default: 8'hFF};
    cs_start();
    for (int k = 0; k < n; k++) xfer_byte(tx[k], rx[k]);
    cs_stop();
  endtask

  task automatic check_writes(input string name);
    check({name, "_wrcnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      wr_ev_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_wraddr"}, 32'(g.a), 32'(e.a));
      check({name, "_wrdata"}, 32'(g.d), 32'(e.d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bytes_t     tx, rx;
    logic [7:0] b;

    reset = 1'b1; SPC = 1'b1; CS = 1'b1; SDI = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    model_reset();
    #23;
    check("rst_sdo", 32'(SDO), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    reset = 1'b0;
    host_check(6'h0F, 8'h33, "rst_id");
    host_check(6'h00, 8'h00, "rst_r00");
    #100;

    // Host-port vector table.
    hv[0] = '{1'b1, 6'h28, 8'hA5, 8'hA5, "hv_w28"};
    hv[1] = '{1'b1, 6'h3E, 8'h11, 8'h11, "hv_w3e"};
    hv[2] = '{1'b1, 6'h3F, 8'h22, 8'h22, "hv_w3f"};
    hv[3] = '{1'b1, 6'h00, 8'h33, 8'h33, "hv_w00"};
    hv[4] = '{1'b1, 6'h0F, 8'h00, 8'h33, "hv_wid"};
    hv[5] = '{1'b0, 6'h0F, 8'h00, 8'h33, "hv_rid"};
    hv[6] = '{1'b0, 6'h10, 8'h00, 8'h00, "hv_r10"};
    hv[7] = '{1'b1, 6'h10, 8'h5C, 8'h5C, "hv_w10"};
    for (int i = 0; i < 8; i++) begin
      if (hv[i].we) host_write(hv[i].addr, hv[i].wdata);
      host_check(hv[i].addr, hv[i].exp, hv[i].name);
    end

    // Single read of 0x28.
    tx = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    check("rd_cmd_sdo", 32'(rx[0]), 32'hFF);
    check("rd_data", 32'(rx[1]), 32'hA5);
    check("rd_busy", 32'(busy_ok), 32'h1);
    check("rd_busy_after", 32'(busy), 32'h0);
    check_writes("rd");

    // Single write 0x57 to 0x20.
    tx = '{8'h20, 8'h57, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    model[6'h20] = 8'h57;
    exp_q.push_back('{6'h20, 8'h57});
    check_writes("wr");
    host_check(6'h20, 8'h57, "wr_host");

    // Auto-increment read wrapping 0x3E -> 0x3F -> 0x00.
    tx = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(tx, 4, rx);
    check("wrap_b0", 32'(rx[1]), 32'h11);
    check("wrap_b1", 32'(rx[2]), 32'h22);
    check("wrap_b2", 32'(rx[3]), 32'h33);

    // ID register is not writable over SPI.
    tx = '{8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    check_writes("id_wr");
    tx = '{8'h8F, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    check("id_read", 32'(rx[1]), 32'h33);

    // Abort after 4 data bits of a write to 0x10.
    cs_start();
    xfer_byte(8'h10, b);
    xfer_byte(8'hFF, b, 4);
    CS = 1'b1;
    #60;
    check("abort_sdo", 32'(SDO), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    #200;
    check_writes("abort");
    host_check(6'h10, 8'h5C, "abort_reg");
    tx = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    check("abort_next_read", 32'(rx[1]), 32'h5C);

    // Same-cycle host write and SPI commit, same and different address.
    cs_start();
    xfer_byte(8'h05, b);
    xfer_byte(8'hBB, b, 8, 1'b1, 6'h05, 8'hAA);
    cs_stop();
    model[6'h05] = 8'hBB;
    exp_q.push_back('{6'h05, 8'hBB});
    check_writes("coll_same");
    host_check(6'h05, 8'hBB, "coll_same_reg");
    cs_start();
    xfer_byte(8'h05, b);
    xfer_byte(8'hCC, b, 8, 1'b1, 6'h06, 8'hAA);
    cs_stop();
    model[6'h05] = 8'hCC;
    model[6'h06] = 8'hAA;
    exp_q.push_back('{6'h05, 8'hCC});
    check_writes("coll_diff");
    host_check(6'h05, 8'hCC, "coll_diff_spi");
    host_check(6'h06, 8'hAA, "coll_diff_host");

    // Async reset in the middle of a read of 0x20 (0x57: SDO is 0 after 3 bits).
    cs_start();
    xfer_byte(8'hA0, b);
    xfer_byte(8'h00, b, 3);
    #20;
    reset = 1'b1;
    #1;
    check("mid_rst_sdo", 32'(SDO), 32'h1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    host_addr = 6'h20;
    #1;
    check("mid_rst_reg", 32'(host_rdata), 32'h00);
    model_reset();
    #30;
    reset = 1'b0;
    xfer_byte(8'h20, b);
    xfer_byte(8'h77, b);
    CS = 1'b1;
    #200;
    check_writes("post_rst_ignored");
    host_check(6'h20, 8'h00, "post_rst_reg");
    tx = '{8'h21, 8'h66, 8'h00, 8'h00, 8'h00};
    frame(tx, 2, rx);
    model[6'h21] = 8'h66;
    exp_q.push_back('{6'h21, 8'h66});
    check_writes("post_rst_frame");

    // Random frames against the register model.
    for (int it = 0; it < 30; it++) begin
      logic       rw, ms;
      logic [5:0] addr, a;
      int         n;
      logic [7:0] specials [4];
      specials = '{8'h0F, 8'h3E, 8'h3F, 8'h00};
      if ($urandom_range(0, 1) == 1) host_write(6'($urandom), 8'($urandom));
      rw   = 1'($urandom);
      ms   = 1'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)][5:0] : 6'($urandom);
      n    = $urandom_range(1, 4);
      tx[0] = {rw, ms, addr};
      for (int k = 1; k < 5; k++) tx[k] = 8'($urandom);
      frame(tx, n + 1, rx);
      check($sformatf("rnd%0d_cmd_sdo", it), 32'(rx[0]), 32'hFF);
      for (int k = 1; k <= n; k++) begin
        a = addr + (ms ? 6'(k - 1) : 6'd0);
        if (rw) begin
          check($sformatf("rnd%0d_rd%0d", it, k), 32'(rx[k]), 32'(model[a]));
        end else begin
          check($sformatf("rnd%0d_wr_sdo%0d", it, k), 32'(rx[k]), 32'hFF);
          if (a != 6'h0F) begin
            model[a] = tx[k];
            exp_q.push_back('{a, tx[k]});
          end
        end
      end
      check_writes($sformatf("rnd%0d", it));
    end

    for (int i = 0; i < 64; i++) host_check(6'(i), model[i], $sformatf("final_r%0h", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (mode 3: SPC idles high; data changes on falling edge, is sampled on rising edge) for the 4-wire sensor protocol our `spi`/`spi_multi` masters speak.
- Holds a 64 x 8 register file that models the accelerometer.
- Used as a synthesizable sensor stand-in for on-board loopback and as the bench responder for master verification.
- A host-side port lets system logic load sample registers and observe SPI writes.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on SPC, CS, SDI.
- ID_ADDR, 6'h0F: address of the read-only identity register.
- ID_VALUE, 8'h33: value returned at ID_ADDR.

Ports:
- clk  input  1  system clock; must be >= 8x SPC frequency.
- reset  input  1  asynchronous, active-high reset.
- SPC  input  1  serial clock from master, asynchronous to clk.
- CS  input  1  chip select, active low, asynchronous.
- SDI  input  1  serial data from master.
- SDO  output  1  serial data to master.
- host_we  input  1  host write strobe.
- host_addr  input  6  host write/read address.
- host_wdata  input  8  host write data.
- host_rdata  output  8  combinational read of regs[host_addr].
- wr_valid  output  1  one-cycle pulse: SPI write committed.
- wr_addr  output  6  address of the committed SPI write.
- wr_data  output  8  data of the committed SPI write.
- busy  output  1  synchronized CS is low.

Behaviour:
- Reset (async): all registers 0 except ID_ADDR = ID_VALUE; SDO=1; wr_valid=0; wr_addr=0; wr_data=0; busy=0; state IDLE; synchronizers preset to 1.
- SPC, CS and SDI each pass through SYNC_STAGES flops. Edge detection uses the synchronized SPC against its previous value:
  - rise = 0->1
  - fall = 1->0
- SDI is sampled from its synchronized copy on rise.
- Frame format, MSB first:
  - bit0 = RW (1 = read)
  - bit1 = MS (1 = auto-increment address)
  - bits2-7 = addr[5:0]
  - then one or more data bytes.
- States:
  - IDLE: SDO=1. Synchronized CS falling -> CMD, bit_cnt=0.
  - CMD: shift SDI into cmd_sr on each rise; bit_cnt++.
    - On the 8th rise: latch rw, ms, addr; bit_cnt=0.
    - rw=1 -> tx_sr <= regs[addr] (snapshot), go RD.
    - rw=0 -> go WR.
  - RD: on each fall, SDO <= tx_sr[7], tx_sr <= tx_sr << 1. Count rises.
    - On the 8th rise: if ms, addr <= addr+1 (6-bit wrap, 63 -> 0); reload tx_sr from the new addr (or the same addr if ms=0); bit_cnt=0; stay RD.
  - WR: shift SDI into rx_sr on each rise.
    - On the 8th rise: commit regs[addr] <= rx_sr unless addr == ID_ADDR (write dropped, no wr_valid).
    - Otherwise pulse wr_valid for one clk with wr_addr/wr_data.
    - Then if ms, addr++ (wrap); bit_cnt=0; stay WR.
- Synchronized CS high in any state -> IDLE next clk:
  - a partial byte is discarded (no commit, no wr_valid);
  - SDO=1.
- SDO latency: updated within SYNC_STAGES+1 clk after a physical SPC fall. It must be stable before the next rise; this is guaranteed by the 8x clock ratio.
- Host port:
  - host_we writes regs[host_addr] in one clk; ID_ADDR is ignored.
  - Same-cycle host write and SPI commit to the same address: the SPI value wins.
  - Different addresses: both commit.
- Read-during-update: RD returns the value snapshotted into tx_sr at byte start. A host write after the snapshot is not visible until the next byte.
- Bit counter is 3 bits wide; 8th rise = bit_cnt==7 on rise.
- Multi-byte with ms=0 repeats the same register every byte.
- Reset asserted mid-frame: immediate return to reset values. The frame resumes only after CS is seen high and then low again.

Decomposition:
- Package spi_pkg: state enum type (IDLE, CMD, RD, WR), RW/MS bit-position constants, ID_ADDR/ID_VALUE defaults, REG_AW=6.
- Sub-module sync_edge (SYNC_STAGES-deep synchronizer plus rise/fall detect), instantiated three times; SDI uses only the level output.

Test Plan:
- Single read: host writes regs[0x28]=8'hA5; master frame 0xA8 (read, MS=0, addr 0x28) -> SDO shifts 1010_0101 on data falls; busy high for the frame; no wr_valid.
- Single write: frame 0x20 then 0x57 -> one wr_valid pulse with wr_addr=0x20, wr_data=0x57; host_rdata at 0x20 reads 0x57.
- Auto-increment wrap: regs[0x3E]=0x11, regs[0x3F]=0x22, regs[0x00]=0x33; read frame with MS=1, addr 0x3E, 3 bytes -> 0x11, 0x22, 0x33.
- ID protection: SPI write 0xFF to 0x0F and host write 0x00 to 0x0F -> read of 0x0F still returns 0x33; no wr_valid.
- Abort: CS raised after 4 data bits of a write to 0x10 -> regs[0x10] unchanged, no wr_valid, SDO=1. The next full frame behaves normally.
- Collision and reset: same-cycle host write 0xAA and SPI commit 0xBB to 0x05 -> regs[0x05]=0xBB. Async reset mid-read -> SDO=1 and busy=0 immediately, regs back to reset values.
